// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state encoding for mmio_uart_tx.
// Imported by the top module and the bench.
package uart_pkg;
  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_RXDATA = 4'h8;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_RXV    = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// Unified core memory port as seen by the UART splitter: address/store data in,
// load data and RAM write enable out. The master side is the core plus RAM.
interface mmio_uart_tx_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [31:0] ramreaddata;
  logic        ramwe;

  modport master (output adr, writedata, memwrite, ramreaddata, input readdata, ramwe);
  modport slave  (input adr, writedata, memwrite, ramreaddata, output readdata, ramwe);
endinterface

// File: rtl/uart_fifo.sv
// Circular TX byte buffer; push is registered, dout shows the head combinationally.
// Push while full is dropped (caller flags overflow); pop while empty is ignored.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO splitter + 8N1 UART transmitter: UART window hits internal regs, else RAM; loads are combinational.
// Optional receiver (rxd port, RXDATA, STATUS.rx_valid) built when UART_RX_EN is defined.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_BASE    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           txd
`ifdef UART_RX_EN
  ,
  input  logic           rxd
`endif
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam int             FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

  logic            hit;
  logic [3:0]      ofs;
  logic            tx_wr;
  logic            st_wr;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  logic [FCW-1:0]  fifo_count;
  tx_state_t       state;
  logic [CW-1:0]   baud;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic            overflow;
  logic            bit_end;
  logic [31:0]     status;

  assign hit      = (bus.adr[31:4] == UART_BASE[31:4]);
  assign ofs      = bus.adr[3:0];
  assign bus.ramwe = bus.memwrite & ~hit;
  assign tx_wr    = bus.memwrite & hit & (ofs == OFS_TXDATA);
  assign st_wr    = bus.memwrite & hit & (ofs == OFS_STATUS);
  assign fifo_pop = (state == IDLE) & ~fifo_empty;
  assign bit_end  = (baud == '0);

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (fifo_pop),
    .din   (bus.writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A dropped byte sets overflow even if software clears it on the same edge.
  always_ff @(posedge clk) begin
    if (reset)                         overflow <= 1'b0;
    else if (tx_wr & fifo_full)        overflow <= 1'b1;
    else if (st_wr & bus.writedata[3]) overflow <= 1'b0;
  end

  // txd is loaded with the level of the state being entered, so it is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            shift <= fifo_dout;
            baud  <= BAUD_LOAD;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            baud    <= BAUD_LOAD;
            txd     <= shift[0];
          end else baud <= baud - 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            baud    <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else txd <= shift[1];
          end else baud <= baud - 1'b1;
        end
        STOP: begin
          if (bit_end) state <= IDLE;
          else         baud  <= baud - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_EN
  logic           rx_s1;
  logic           rx_s2;
  tx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [7:0]     rx_shift;
  logic [7:0]     rx_data;
  logic [2:0]     rx_idx;
  logic           rx_valid;
  logic           rx_clr;

  assign rx_clr = bus.memwrite & hit & (ofs == OFS_RXDATA);

  // Half-bit initial count puts every later sample near the middle of its bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_idx   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      if (rx_clr) rx_valid <= 1'b0;
      case (rx_state)
        IDLE: if (!rx_s2) begin
          rx_state <= START;
          rx_cnt   <= CW'(CLKS_PER_BIT / 2);
        end
        START: begin
          if (rx_cnt == '0) begin
            rx_state <= rx_s2 ? IDLE : DATA;
            rx_idx   <= '0;
            rx_cnt   <= BAUD_LOAD;
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            rx_cnt   <= BAUD_LOAD;
            if (rx_idx == 3'd7) rx_state <= STOP;
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        STOP: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
            rx_state <= IDLE;
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end
`endif

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = (state != IDLE);
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_OVF]      = overflow;
    status[ST_CNT_LO +: 4] = 4'(fifo_count);
`ifdef UART_RX_EN
    status[ST_RXV]      = rx_valid;
`endif
  end

  always_comb begin
    bus.readdata = bus.ramreaddata;
    if (hit) begin
      case (ofs)
        OFS_STATUS: bus.readdata = status;
`ifdef UART_RX_EN
        OFS_RXDATA: bus.readdata = {24'h0, rx_data};
`endif
        default:    bus.readdata = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + random bench for mmio_uart_tx; reference is a byte queue with frame timing arithmetic.
// Receiver steps are compiled only when UART_RX_EN is defined.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd;
`ifdef UART_RX_EN
  logic rxd = 1'b1;
`endif

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.UART_BASE(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
`ifdef UART_RX_EN
    ,
    .rxd   (rxd)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: pending bytes, the byte on the wire and the edge it was popped.
  logic [7:0] q[$];
  logic [7:0] fbyte = 8'h0;
  int         edge_n = 0;
  int         p_edge = -1000;
  int         free_edge = 0;
  bit         ovf_m = 1'b0;
  bit         rxv_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int d = edge_n - p_edge;
    if (d >= 0 && d < FRAME) begin
      int b = d / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return fbyte[b-1];
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = 32'h0;
    int d = edge_n - p_edge;
    s[0]   = (d >= 0 && d < FRAME);
    s[1]   = (q.size() == DEPTH);
    s[2]   = (q.size() == 0);
    s[3]   = ovf_m;
    s[7:4] = 4'(q.size());
`ifdef UART_RX_EN
    s[8]   = rxv_m;
`endif
    return s;
  endfunction

  // One clock edge with the currently driven bus inputs; model advances, txd checked.
  task automatic step();
    logic r, st_tx, st_st, st_rx, full_b;
    logic [31:0] wd;
    r     = reset;
    st_tx = bus.memwrite && (bus.adr == BASE);
    st_st = bus.memwrite && (bus.adr == BASE + 32'h4);
    st_rx = bus.memwrite && (bus.adr == BASE + 32'h8);
    wd    = bus.writedata;
    @(posedge clk);
    edge_n++;
    if (r) begin
      q.delete();
      ovf_m = 1'b0;
      rxv_m = 1'b0;
      p_edge = -1000;
      free_edge = edge_n + 1;
    end else begin
      full_b = (q.size() == DEPTH);
      if (q.size() > 0 && edge_n >= free_edge) begin
        fbyte = q.pop_front();
        p_edge = edge_n;
        free_edge = edge_n + FRAME + 1;
      end
      if (st_tx) begin
        if (full_b) ovf_m = 1'b1;
        else q.push_back(wd[7:0]);
      end
      if (st_st && wd[3]) ovf_m = 1'b0;
      if (st_rx) rxv_m = 1'b0;
    end
    #1;
    chk("txd", {31'b0, txd}, {31'b0, exp_txd()});
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus.adr = a;
    bus.memwrite = 1'b0;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr = a;
    bus.writedata = d;
    bus.memwrite = 1'b1;
    #1;
    chk("ramwe_store", {31'b0, bus.ramwe}, {31'b0, (a[31:4] != BASE[31:4])});
    step();
    bus.memwrite = 1'b0;
    bus.adr = 32'h0000_1000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rd(BASE + 32'h4, "status", exp_status());
    end
  endtask

`ifdef UART_RX_EN
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) step();
    end
    rxd = stop;
    repeat (CPB) step();
    rxd = 1'b1;
  endtask
`endif

  initial begin
    logic [31:0] a, d;
    bus.adr = 32'h0000_1000;
    bus.writedata = 32'h0;
    bus.memwrite = 1'b0;
    bus.ramreaddata = 32'h0;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    rd(BASE + 32'h4, "status_reset", 32'h4);
    chk("ramwe_idle", {31'b0, bus.ramwe}, 32'h0);

    // Single frame 0x55; txd checked every cycle against the frame model.
    wr(BASE, 32'h55);
    idle(FRAME + 4);
    rd(BASE + 32'h4, "status_after_55", 32'h4);

    // RAM passthrough and window boundaries.
    wr(32'h0000_0010, 32'h0000_0010);
    rd(BASE + 32'h4, "status_after_ram_wr", 32'h4);
    bus.ramreaddata = 32'hDEADBEEF;
    rd(32'h0000_0010, "ram_load", 32'hDEADBEEF);
    rd(BASE + 32'h10, "above_window", 32'hDEADBEEF);
    rd(BASE - 32'h1, "below_window", 32'hDEADBEEF);
    rd(BASE + 32'hC, "ofs_c_zero", 32'h0);
    rd(BASE, "txdata_reads_zero", 32'h0);
`ifndef UART_RX_EN
    rd(BASE + 32'h8, "ofs_8_zero", 32'h0);
`endif

    // Overflow: six back-to-back stores into a 4-deep FIFO.
    for (int i = 1; i <= 6; i++) wr(BASE, i);
    rd(BASE + 32'h4, "status_overflow", 32'h4B);
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, "status_ovf_clr", 32'h43);
    idle(5 * (FRAME + 1) + 4);
    rd(BASE + 32'h4, "status_drained", 32'h4);

    // Reset mid-DATA of 0xA5, with a simultaneous store that must be lost.
    wr(BASE, 32'hA5);
    idle(12);
    bus.adr = BASE;
    bus.writedata = 32'h77;
    bus.memwrite = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.memwrite = 1'b0;
    chk("txd_after_reset", {31'b0, txd}, 32'h1);
    rd(BASE + 32'h4, "status_after_reset", 32'h4);
    wr(BASE, 32'h0F);
    idle(FRAME + 4);
    rd(BASE + 32'h4, "status_after_0f", 32'h4);

    // Random mix of UART stores, status clears, RAM traffic and idle gaps.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 4))
        0: wr(BASE, $urandom);
        1: begin
          a = $urandom & 32'h7FFF_FFF0;
          wr(a, $urandom);
        end
        2: begin
          a = $urandom & 32'h7FFF_FFFC;
          d = $urandom;
          bus.ramreaddata = d;
          rd(a, "ram_load_rand", d);
          step();
        end
        3: wr(BASE + 32'h4, $urandom);
        default: idle($urandom_range(1, 30));
      endcase
      rd(BASE + 32'h4, "status_rand", exp_status());
    end
    idle(DEPTH * (FRAME + 1) + 10);
    rd(BASE + 32'h4, "status_final", {28'h0, ovf_m, 3'b100});

`ifdef UART_RX_EN
    rx_frame(8'h3C, 1'b1);
    repeat (8) step();
    rxv_m = 1'b1;
    rd(BASE + 32'h4, "rx_valid_set", exp_status());
    rd(BASE + 32'h8, "rxdata", 32'h3C);
    wr(BASE + 32'h8, 32'h0);
    rd(BASE + 32'h4, "rx_valid_clr", exp_status());
    rx_frame(8'hA7, 1'b0);
    repeat (8) step();
    rd(BASE + 32'h4, "rx_bad_stop", exp_status());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
